// File: rtl/axis_seq_generator.sv
// AXI4-Stream sequence source: emits fixed-length packets of geometric, incrementing,
// LFSR or constant values, with full valid/ready hold and tlast framing.
// Optional macro GEN_PKT_COUNTER_EN adds a 16-bit completed-packet counter output.
module axis_seq_generator #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned PKT_LEN   = 8,
  parameter int unsigned MULT      = 3,
  parameter int unsigned SEED      = 1
) (
  input  logic                   m00_axis_aclk,
  input  logic                   m00_axis_aresetn,
  input  logic                   m00_axis_enable,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_restart,
  input  logic                   m00_axis_tready,
  output logic [DATA_SIZE-1:0]   m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
`ifdef GEN_PKT_COUNTER_EN
  output logic [15:0]            pkt_count,
`endif
  output logic                   busy
);

  localparam int unsigned CntW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CntW-1:0]      LastBeat = CntW'(PKT_LEN - 1);
  localparam logic [DATA_SIZE-1:0] SeedVal  = DATA_SIZE'(SEED);
  localparam logic [DATA_SIZE-1:0] MultVal  = DATA_SIZE'(MULT);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  localparam logic [1:0] ModeGeom  = 2'b00;
  localparam logic [1:0] ModeIncr  = 2'b01;
  localparam logic [1:0] ModeLfsr  = 2'b10;

  logic [0:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] data_q, data_d, data_next;
  logic [CntW-1:0]      beat_q, beat_d;
  logic [1:0]           mode_q, mode_d;
  logic                 pend_q, pend_d;
  logic                 hs, last_beat, pkt_start;

  assign hs        = (state_q == StSend) && m00_axis_tready;
  assign last_beat = (beat_q == LastBeat);

  // Successor of the current value under the mode latched for this packet
  always_comb begin
    data_next = SeedVal;
    case (mode_q)
      ModeGeom: data_next = data_q * MultVal;
      ModeIncr: data_next = data_q + DATA_SIZE'(1);
      ModeLfsr: begin
        // An all-zero register would lock up, so recover from SEED
        if (data_q == '0) begin
          data_next = SeedVal;
        end else begin
          data_next = {data_q[DATA_SIZE-2:0],
                       data_q[DATA_SIZE-1] ^ data_q[DATA_SIZE-2] ^ data_q[0]};
        end
      end
      default:  data_next = SeedVal;
    endcase
  end

  // Packet FSM, beat counter, mode latch and restart bookkeeping
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    beat_d    = beat_q;
    mode_d    = mode_q;
    pkt_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (m00_axis_enable) begin
          state_d   = StSend;
          pkt_start = 1'b1;
        end
      end
      default: begin
        if (hs) begin
          data_d = data_next;
          if (last_beat) begin
            beat_d = '0;
            if (m00_axis_enable) begin
              pkt_start = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            beat_d = beat_q + CntW'(1);
          end
        end
      end
    endcase

    // A restart arriving in the same cycle as a packet start is honoured immediately
    if (pkt_start) begin
      mode_d = cfg_mode;
      pend_d = 1'b0;
      if (pend_q || cfg_restart) begin
        data_d = SeedVal;
      end
    end else begin
      pend_d = pend_q | cfg_restart;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      state_q <= StIdle;
      data_q  <= SeedVal;
      beat_q  <= '0;
      mode_q  <= ModeGeom;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
    end
  end

`ifdef GEN_PKT_COUNTER_EN
  logic [15:0] pkt_cnt_q;

  // Counts completed packets; free-running, unaffected by restart
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      pkt_cnt_q <= '0;
    end else if (hs && last_beat) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_count = pkt_cnt_q;
`endif

  assign m00_axis_tdata  = data_q;
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tvalid = (state_q == StSend);
  assign m00_axis_tlast  = (state_q == StSend) && last_beat;
  assign busy            = (state_q == StSend);

endmodule

// File: tb/tb_axis_seq_generator.sv
// Self-checking bench: three generator configurations driven by shared stimulus, each
// tracked by a behavioural packet model, plus literal expectations for the directed cases.
module tb_axis_seq_generator;

  localparam int NumDut = 3;

  typedef struct packed {
    logic        active;
    logic [3:0]  beat;
    logic [31:0] val;
    logic [1:0]  mode;
    logic        pend;
    logic [15:0] pkt;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rstn, en, restart, tready;
  logic [1:0] mode;
  logic       chk_en = 1'b0;
  int         n_run  = 0;
  int         n_fail = 0;

  logic [31:0] o_tdata   [NumDut];
  logic        o_tvalid  [NumDut];
  logic        o_tlast   [NumDut];
  logic        o_busy    [NumDut];
  logic        o_strb_ok [NumDut];
  mdl_t        mdl       [NumDut];
`ifdef GEN_PKT_COUNTER_EN
  logic [15:0] o_pkt     [NumDut];
`endif

  logic [31:0] exp_a [8] = '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81, 32'd243, 32'd729, 32'd2187};
  logic [31:0] exp_b [8] = '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81, 32'd243, 32'd217, 32'd139};

  always #5 clk = ~clk;

  function automatic int f_len(input int g);
    return (g == 1) ? 8 : 4;
  endfunction

  // Sequence successor from the rules, evaluated at width w
  function automatic logic [31:0] f_next(input logic [31:0] d, input logic [1:0] m,
                                         input int w, input logic [31:0] seed);
    logic [31:0] mask, r;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (m)
      2'd0:    r = d * 32'd3;
      2'd1:    r = d + 32'd1;
      2'd2:    r = (d == 32'd0) ? seed : ((d << 1) | 32'(d[w-1] ^ d[w-2] ^ d[0]));
      default: r = seed;
    endcase
    return r & mask;
  endfunction

  // One clock of packet-level behaviour
  function automatic mdl_t f_step(input mdl_t s, input int w, input int len,
                                  input logic [31:0] seed, input logic rst_n, input logic go,
                                  input logic rdy, input logic rs, input logic [1:0] md);
    mdl_t n;
    logic start;
    n     = s;
    start = 1'b0;
    if (!rst_n) begin
      n     = '0;
      n.val = seed;
      return n;
    end
    if (!s.active) begin
      start = go;
    end else if (rdy) begin
      n.val = f_next(s.val, s.mode, w, seed);
      if (int'(s.beat) == len - 1) begin
        n.beat   = '0;
        n.pkt    = s.pkt + 16'd1;
        n.active = 1'b0;
        start    = go;
      end else begin
        n.beat = s.beat + 4'd1;
      end
    end
    if (start) begin
      n.active = 1'b1;
      n.mode   = md;
      if (s.pend || rs) n.val = seed;
      n.pend = 1'b0;
    end else begin
      n.pend = s.pend | rs;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    en      = 1'b0;
    restart = 1'b0;
    mode    = 2'd0;
    tready  = 1'b1;
    cyc(2);
    rstn = 1'b1;
  endtask

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    localparam int unsigned W = (g == 1) ? 8 : 32;
    localparam int unsigned L = (g == 1) ? 8 : 4;
    localparam logic [31:0] S = (g == 2) ? 32'hFFFF_FFFE : 32'd1;

    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tvalid, tlast, busy;
    mdl_t           m;
`ifdef GEN_PKT_COUNTER_EN
    logic [15:0]    pkt_count;
    assign o_pkt[g] = pkt_count;
`endif

    axis_seq_generator #(
      .DATA_SIZE(W),
      .PKT_LEN  (L),
      .MULT     (3),
      .SEED     (S)
    ) u_dut (
      .m00_axis_aclk   (clk),
      .m00_axis_aresetn(rstn),
      .m00_axis_enable (en),
      .cfg_mode        (mode),
      .cfg_restart     (restart),
      .m00_axis_tready (tready),
      .m00_axis_tdata  (tdata),
      .m00_axis_tstrb  (tstrb),
      .m00_axis_tvalid (tvalid),
      .m00_axis_tlast  (tlast),
`ifdef GEN_PKT_COUNTER_EN
      .pkt_count       (pkt_count),
`endif
      .busy            (busy)
    );

    assign o_tdata[g]   = 32'(tdata);
    assign o_tvalid[g]  = tvalid;
    assign o_tlast[g]   = tlast;
    assign o_busy[g]    = busy;
    assign o_strb_ok[g] = &tstrb;
    assign mdl[g]       = m;

    initial begin
      m = '0;
      forever begin
        @(posedge clk);
        m = f_step(m, int'(W), int'(L), S, rstn, en, tready, restart, mode);
      end
    end
  end

  // Every-cycle comparison of all instances against their models
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NumDut; i++) begin
          chk("tvalid", i, 32'(o_tvalid[i]), 32'(mdl[i].active));
          chk("busy",   i, 32'(o_busy[i]),   32'(mdl[i].active));
          chk("tstrb",  i, 32'(o_strb_ok[i]), 32'd1);
          chk("tdata",  i, o_tdata[i], mdl[i].val);
          chk("tlast",  i, 32'(o_tlast[i]),
              32'(mdl[i].active && (int'(mdl[i].beat) == f_len(i) - 1)));
`ifdef GEN_PKT_COUNTER_EN
          chk("pkt_count", i, 32'(o_pkt[i]), 32'(mdl[i].pkt));
`endif
        end
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    en      = 1'b0;
    restart = 1'b0;
    mode    = 2'd0;
    tready  = 1'b1;
    cyc(2);
    chk_en = 1'b1;

    // Reset state
    chk("rst_tdata",  0, o_tdata[0], 32'd1);
    chk("rst_tdata",  2, o_tdata[2], 32'hFFFF_FFFE);
    chk("rst_tvalid", 0, 32'(o_tvalid[0]), 32'd0);
    chk("rst_tlast",  0, 32'(o_tlast[0]), 32'd0);
    chk("rst_busy",   0, 32'(o_busy[0]), 32'd0);
    chk("rst_tstrb",  0, 32'(o_strb_ok[0]), 32'd1);

    // Geometric packets back to back; 8-bit instance wraps
    rstn = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("t1_tvalid", 0, 32'(o_tvalid[0]), 32'd1);
      chk("t1_tdata",  0, o_tdata[0], exp_a[i]);
      chk("t1_tlast",  0, 32'(o_tlast[0]), 32'((i % 4) == 3));
      chk("t3_tdata",  1, o_tdata[1], exp_b[i]);
      chk("t3_tlast",  1, 32'(o_tlast[1]), 32'(i == 7));
    end
    en = 1'b0;
    cyc(3);

    // Backpressure hold on beat value 9
    do_reset();
    en = 1'b1;
    cyc(3);
    chk("t2_tdata", 0, o_tdata[0], 32'd9);
    tready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      chk("t2_hold_tvalid", 0, 32'(o_tvalid[0]), 32'd1);
      chk("t2_hold_tdata",  0, o_tdata[0], 32'd9);
      chk("t2_hold_tlast",  0, 32'(o_tlast[0]), 32'd0);
    end
    tready = 1'b1;
    cyc(1);
    chk("t2_after_tdata", 0, o_tdata[0], 32'd27);
    chk("t2_after_tlast", 0, 32'(o_tlast[0]), 32'd1);
    en = 1'b0;
    cyc(7);

    // Increment with wrap; enable dropped mid-packet
    do_reset();
    mode = 2'd1;
    en   = 1'b1;
    cyc(1);
    chk("t4_b1", 2, o_tdata[2], 32'hFFFF_FFFE);
    cyc(1);
    chk("t4_b2", 2, o_tdata[2], 32'hFFFF_FFFF);
    en = 1'b0;
    cyc(1);
    chk("t4_b3", 2, o_tdata[2], 32'd0);
    cyc(1);
    chk("t4_b4", 2, o_tdata[2], 32'd1);
    chk("t4_b4_tlast", 2, 32'(o_tlast[2]), 32'd1);
    cyc(1);
    chk("t4_idle_tvalid", 2, 32'(o_tvalid[2]), 32'd0);
    chk("t4_idle_busy",   2, 32'(o_busy[2]), 32'd0);
    cyc(6);

    // LFSR mode
    do_reset();
    mode = 2'd2;
    en   = 1'b1;
    cyc(1);
    chk("lfsr_b1", 0, o_tdata[0], 32'd1);
    cyc(1);
    chk("lfsr_b2", 0, o_tdata[0], 32'd3);
    cyc(1);
    chk("lfsr_b3", 0, o_tdata[0], 32'd7);
    chk("lfsr_b3", 1, o_tdata[1], 32'd7);
    cyc(1);
    chk("lfsr_b4", 0, o_tdata[0], 32'd15);
    cyc(8);
    en = 1'b0;
    cyc(10);

    // Restart and mode change mid-packet take effect at the next packet
    do_reset();
    en = 1'b1;
    cyc(1);
    chk("t5_b1", 0, o_tdata[0], 32'd1);
    cyc(1);
    chk("t5_b2", 0, o_tdata[0], 32'd3);
    restart = 1'b1;
    mode    = 2'd3;
    cyc(1);
    restart = 1'b0;
    chk("t5_b3", 0, o_tdata[0], 32'd9);
    cyc(1);
    chk("t5_b4", 0, o_tdata[0], 32'd27);
    cyc(1);
    chk("t5_p2b1", 0, o_tdata[0], 32'd1);
`ifdef GEN_PKT_COUNTER_EN
    chk("t5_pkt_count", 0, 32'(o_pkt[0]), 32'd1);
`endif
    cyc(1);
    chk("t5_p2b2", 0, o_tdata[0], 32'd1);
    cyc(1);
    chk("t5_p2b3", 0, o_tdata[0], 32'd1);

    // Reset while a packet is in flight
    rstn = 1'b0;
    cyc(1);
    chk("t6_tvalid", 0, 32'(o_tvalid[0]), 32'd0);
    chk("t6_tlast",  0, 32'(o_tlast[0]), 32'd0);
    chk("t6_tdata",  0, o_tdata[0], 32'd1);
    chk("t6_busy",   0, 32'(o_busy[0]), 32'd0);
`ifdef GEN_PKT_COUNTER_EN
    chk("t6_pkt_count", 0, 32'(o_pkt[0]), 32'd0);
`endif
    rstn = 1'b1;
    en   = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
